// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, memory-stage FSM encoding,
// default data-memory size and icode classification helpers.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam int MEM_BYTES_DEFAULT = 1024;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } mem_state_t;

    function automatic logic mem_reads(input logic [3:0] ic);
        return (ic == IMRMOVQ) || (ic == IRET) || (ic == IPOPQ);
    endfunction

    function automatic logic mem_writes(input logic [3:0] ic);
        return (ic == IRMMOVQ) || (ic == ICALL) || (ic == IPUSHQ);
    endfunction

    // ret/popq address the stack through valA; every other access uses valE.
    function automatic logic addr_from_vala(input logic [3:0] ic);
        return (ic == IRET) || (ic == IPOPQ);
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Byte-wide data memory: asynchronous read port, synchronous write port.
// Contents are deliberately not reset.
module dmem_byte_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: moves one 64-bit word to/from a byte RAM over eight
// little-endian beats, with range checking and a one-cycle done pulse.
import y86_pkg::*;

module memory_stage #(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic [63:0] valP,
    output logic [63:0] valM,
    output logic        busy,
    output logic        done,
    output logic        dmem_error
);

    localparam int AW = $clog2(MEM_BYTES);

    mem_state_t  state, state_nxt;
    logic [2:0]  beat;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [55:0] rbuf;

    logic        rd_req, wr_req, addr_err, accept;
    logic [63:0] sel_addr, sel_wdata;

    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_rdata;
    logic          ram_we;

    always_comb begin
        rd_req    = mem_reads(icode);
        wr_req    = mem_writes(icode);
        sel_addr  = addr_from_vala(icode) ? valA : valE;
        sel_wdata = (icode == ICALL) ? valP : valA;
        // Checking the base against MEM_BYTES-8 guarantees addr+7 stays in range.
        addr_err  = (rd_req || wr_req) && (sel_addr > 64'(MEM_BYTES - 8));
    end

    assign accept = (state == S_IDLE) && start;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (addr_err || !(rd_req || wr_req)) state_nxt = S_DONE;
                    else if (rd_req)                     state_nxt = S_READ;
                    else                                 state_nxt = S_WRITE;
                end
            end
            S_READ, S_WRITE: begin
                if (beat == 3'd7) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy     = (state == S_READ) || (state == S_WRITE);
    assign done     = (state == S_DONE);
    assign ram_we   = (state == S_WRITE);
    assign ram_addr = AW'(addr_q + {61'd0, beat});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            beat       <= 3'd0;
            valM       <= 64'd0;
            dmem_error <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                beat       <= 3'd0;
                dmem_error <= addr_err;
            end else if (busy) begin
                beat <= beat + 3'd1;
            end
            if (state == S_READ && beat == 3'd7) begin
                valM <= {ram_rdata, rbuf};
            end
        end
    end

    // Operand registers: write data shifts out LSB-first, read bytes shift in MSB-first.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
        end else if (state == S_WRITE) begin
            wdata_q <= {8'd0, wdata_q[63:8]};
        end
        if (state == S_READ) begin
            rbuf <= {ram_rdata, rbuf[55:8]};
        end
    end

    dmem_byte_ram #(
        .DEPTH (MEM_BYTES),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_addr),
        .wdata (wdata_q[7:0]),
        .raddr (ram_addr),
        .rdata (ram_rdata)
    );

endmodule
